// File: rtl/uart_fifo_peripheral.sv
// UART peripheral: TX/RX FIFOs, tick generator, TX serialiser, 16x-oversampled receiver.
// Optional macro UART_LOOPBACK_EN: receiver fed from the TX serialiser, tx pin held high.

module uart_fifo_sync #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 32,
  parameter int AF_THRESH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Flags come straight from the registered occupancy, so a push into a full FIFO is lost even with a pop
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign afull_o = (cnt_q >= CW'(AF_THRESH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end
endmodule

module uart_fifo_peripheral #(
  parameter int BAUD_RATE          = 9600,
  parameter int CLOCK_FREQ         = 10000000,
  parameter int PARITY             = 0,   // 0 none, 1 even, 2 odd
  parameter int DATA_BITS          = 8,
  parameter int STOP_BITS          = 1,
  parameter int FIFO_DEPTH         = 16,
  parameter int ALMOST_FULL_THRESH = 12,
  parameter int USB_PACKET_WIDTH   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic                        tx,
  input  logic [USB_PACKET_WIDTH-1:0] tx_data,
  input  logic                        tx_valid,
  output logic                        tx_full,
  output logic [USB_PACKET_WIDTH-1:0] rx_data,
  input  logic                        rx_read,
  output logic                        rx_empty,
  output logic                        rx_almost_full,
  output logic                        rx_full,
  output logic                        rx_overrun
);
  localparam int   W       = USB_PACKET_WIDTH;
  localparam int   DIV_RAW = (CLOCK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int   DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int   DW      = $clog2(DIV + 1);
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_PUSH, R_WAIT} rx_state_e;

  logic [DW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) div_q <= '0;
    else             div_q <= div_q + DW'(1);
  end

  logic                 tx_pop, tx_empty, tx_afull_unused, tx_ser, rx_in;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_data_unused;

  assign tx_data_unused = ^tx_data[W-1:DATA_BITS];

  uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS), .AF_THRESH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst(rst), .push_i(tx_valid), .data_i(tx_data[DATA_BITS-1:0]), .pop_i(tx_pop),
    .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .afull_o(tx_afull_unused)
  );

  tx_state_e            t_state_q, t_state_d;
  logic [3:0]           t_tcnt_q, t_tcnt_d, t_bcnt_q, t_bcnt_d;
  logic [DATA_BITS-1:0] t_shift_q, t_shift_d;
  logic                 t_par_q, t_par_d, t_bit_end;

  assign t_bit_end = tick && (t_tcnt_q == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      t_state_q <= T_IDLE;
      t_tcnt_q  <= '0;
      t_bcnt_q  <= '0;
    end else begin
      t_state_q <= t_state_d;
      t_tcnt_q  <= t_tcnt_d;
      t_bcnt_q  <= t_bcnt_d;
    end
    t_shift_q <= t_shift_d;
    t_par_q   <= t_par_d;
  end

  always_comb begin
    t_state_d = t_state_q;
    t_tcnt_d  = t_tcnt_q;
    t_bcnt_d  = t_bcnt_q;
    t_shift_d = t_shift_q;
    t_par_d   = t_par_q;
    tx_pop    = 1'b0;
    if (t_state_q != T_IDLE && tick) t_tcnt_d = t_tcnt_q + 4'd1;
    case (t_state_q)
      T_IDLE: if (!tx_empty) begin
        tx_pop    = 1'b1;
        t_shift_d = tx_head;
        t_par_d   = (^tx_head) ^ PAR_ODD;
        t_tcnt_d  = '0;
        t_bcnt_d  = '0;
        t_state_d = T_START;
      end
      T_START: if (t_bit_end) t_state_d = T_DATA;
      T_DATA: if (t_bit_end) begin
        t_shift_d = t_shift_q >> 1;
        if (t_bcnt_q == 4'(DATA_BITS - 1)) begin
          t_bcnt_d  = '0;
          t_state_d = PAR_EN ? T_PAR : T_STOP;
        end else begin
          t_bcnt_d = t_bcnt_q + 4'd1;
        end
      end
      T_PAR: if (t_bit_end) t_state_d = T_STOP;
      T_STOP: if (t_bit_end) begin
        if (t_bcnt_q == 4'(STOP_BITS - 1)) t_state_d = T_IDLE;
        else                               t_bcnt_d  = t_bcnt_q + 4'd1;
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    case (t_state_q)
      T_START: tx_ser = 1'b0;
      T_DATA:  tx_ser = t_shift_q[0];
      T_PAR:   tx_ser = t_par_q;
      default: tx_ser = 1'b1;
    endcase
  end

`ifdef UART_LOOPBACK_EN
  logic rx_unused;
  assign rx_unused = rx;
  assign rx_in     = tx_ser;
  assign tx        = 1'b1;
`else
  assign rx_in = rx;
  assign tx    = tx_ser;
`endif

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_e            r_state_q, r_state_d;
  logic [3:0]           r_tcnt_q, r_tcnt_d, r_bcnt_q, r_bcnt_d;
  logic [DATA_BITS-1:0] r_shift_q, r_shift_d;
  logic                 r_perr_q, r_perr_d, r_ferr_q, r_ferr_d, r_bit_end, rx_push, ovr_q;
  logic [W-1:0]         rx_word;

  assign r_bit_end = tick && (r_tcnt_q == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_tcnt_q  <= '0;
      r_bcnt_q  <= '0;
      ovr_q     <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_tcnt_q  <= r_tcnt_d;
      r_bcnt_q  <= r_bcnt_d;
      ovr_q     <= rx_push && rx_full;
    end
    r_shift_q <= r_shift_d;
    r_perr_q  <= r_perr_d;
    r_ferr_q  <= r_ferr_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    r_tcnt_d  = r_tcnt_q;
    r_bcnt_d  = r_bcnt_q;
    r_shift_d = r_shift_q;
    r_perr_d  = r_perr_q;
    r_ferr_d  = r_ferr_q;
    rx_push   = 1'b0;
    if (tick) r_tcnt_d = r_tcnt_q + 4'd1;
    case (r_state_q)
      R_IDLE: if (rx_prev_q && !rx_s2_q) begin
        r_tcnt_d  = '0;
        r_perr_d  = 1'b0;
        r_state_d = R_START;
      end
      // Half a bit into the start bit: confirm it, then sample every 16 ticks from here
      R_START: if (tick && r_tcnt_q == 4'd7) begin
        r_tcnt_d  = '0;
        r_bcnt_d  = '0;
        r_state_d = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (r_bit_end) begin
        r_shift_d = {rx_s2_q, r_shift_q[DATA_BITS-1:1]};
        if (r_bcnt_q == 4'(DATA_BITS - 1)) r_state_d = PAR_EN ? R_PAR : R_STOP;
        else                               r_bcnt_d  = r_bcnt_q + 4'd1;
      end
      R_PAR: if (r_bit_end) begin
        r_perr_d  = rx_s2_q ^ (^r_shift_q) ^ PAR_ODD;
        r_state_d = R_STOP;
      end
      R_STOP: if (r_bit_end) begin
        r_ferr_d  = !rx_s2_q;
        r_state_d = R_PUSH;
      end
      R_PUSH: begin
        rx_push   = 1'b1;
        r_state_d = r_ferr_q ? R_WAIT : R_IDLE;
      end
      R_WAIT: if (rx_s2_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_word                = '0;
    rx_word[DATA_BITS-1:0] = r_shift_q;
    rx_word[W-1]           = r_ferr_q;
    rx_word[W-2]           = r_perr_q;
  end

  uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .WIDTH(W), .AF_THRESH(ALMOST_FULL_THRESH)) u_rxf (
    .clk(clk), .rst(rst), .push_i(rx_push), .data_i(rx_word), .pop_i(rx_read),
    .data_o(rx_data), .full_o(rx_full), .empty_o(rx_empty), .afull_o(rx_almost_full)
  );

  assign rx_overrun = ovr_q;
endmodule
